// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM block-copy / block-fill engine.
package ram_dma_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_engine_if.sv
// Request/status and RAM bus signals of the DMA engine, bundled with
// master (engine side) and slave (system/RAM side) views.
interface ram_dma_engine_if
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              start;
  logic              abort;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic [7:0]        fill_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_oe;
  logic [7:0]        mem_rdata;

  modport master (
    input  start, abort, mode, src_addr, dst_addr, length, fill_data, mem_rdata,
    output busy, done, mem_addr, mem_wdata, mem_we, mem_oe
  );

  modport slave (
    output start, abort, mode, src_addr, dst_addr, length, fill_data, mem_rdata,
    input  busy, done, mem_addr, mem_wdata, mem_we, mem_oe
  );

endinterface

// File: rtl/ram_dma_engine.sv
// Bus-master DMA engine: forward byte-by-byte RAM-to-RAM copy (2 cycles/byte)
// or constant fill (1 cycle/byte), holding the CPU off through busy.
module ram_dma_engine
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  ram_dma_engine_if.master bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RD   = ST_RD;
  localparam logic [1:0] WR   = ST_WR;
  localparam logic [1:0] FIN  = ST_FIN;

  logic [1:0]        state_reg, state_next;
  logic              mode_reg, mode_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [LEN_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic              oe_reg, oe_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic [ADDR_W-1:0] src_inc;
  logic [ADDR_W-1:0] dst_inc;
  logic              last_byte;
  logic              accept;

  assign src_inc   = src_reg + ADDR_W'(1);
  assign dst_inc   = dst_reg + ADDR_W'(1);
  assign last_byte = (count_reg == LEN_W'(1));
  assign accept    = bus.start && !bus.abort;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    count_next = count_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;
    oe_next    = oe_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          mode_next  = bus.mode;
          src_next   = bus.src_addr;
          dst_next   = bus.dst_addr;
          count_next = bus.length;
          busy_next  = 1'b1;
          if (bus.length == '0) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else if (bus.mode == MODE_FILL) begin
            // The fill byte lives in the write-data register for the whole run.
            state_next = WR;
            addr_next  = bus.dst_addr;
            wdata_next = bus.fill_data;
            we_next    = 1'b1;
          end else begin
            state_next = RD;
            addr_next  = bus.src_addr;
            oe_next    = 1'b1;
          end
        end
      end

      RD: begin
        if (bus.abort) begin
          state_next = IDLE;
          we_next    = 1'b0;
          oe_next    = 1'b0;
          busy_next  = 1'b0;
        end else begin
          state_next = WR;
          wdata_next = bus.mem_rdata;
          addr_next  = dst_reg;
          we_next    = 1'b1;
          oe_next    = 1'b0;
        end
      end

      WR: begin
        // An abort here still lets this cycle's falling-edge write land.
        if (bus.abort) begin
          state_next = IDLE;
          we_next    = 1'b0;
          oe_next    = 1'b0;
          busy_next  = 1'b0;
        end else begin
          count_next = count_reg - LEN_W'(1);
          src_next   = src_inc;
          dst_next   = dst_inc;
          if (last_byte) begin
            state_next = FIN;
            we_next    = 1'b0;
            done_next  = 1'b1;
          end else if (mode_reg == MODE_COPY) begin
            state_next = RD;
            addr_next  = src_inc;
            we_next    = 1'b0;
            oe_next    = 1'b1;
          end else begin
            addr_next  = dst_inc;
          end
        end
      end

      FIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        we_next    = 1'b0;
        oe_next    = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_COPY;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      oe_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      oe_reg    <= oe_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_we    = we_reg;
  assign bus.mem_oe    = oe_reg;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Bench for ram_dma_engine: directed table, hand-written corner sequences and
// random transfers checked against a byte-level memory model.
module tb_ram_dma_engine;
  import ram_dma_pkg::*;

  localparam int AW  = 15;
  localparam int LW  = 16;
  localparam int MSK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_dma_engine_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  ram_dma_engine #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // System RAM: combinational read, falling-edge write; tb port for preloads.
  logic [7:0]    ram [0:(1<<AW)-1];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [7:0]    tb_data = '0;

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    else if (tb_we) ram[tb_addr] <= tb_data;
  end

  bit [7:0] ref_mem [int];
  int checks = 0;
  int errors = 0;

  typedef struct {
    string    name;
    bit       md;
    int       sa;
    int       da;
    int       ln;
    bit [7:0] fd;
    int       exp_done;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input int obs[$], input int exp[$]);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      if (bad < 0 && obs[i] != exp[i]) bad = i;
    if (obs.size() != exp.size()) begin
      errors++;
      $display("FAIL %s: got %0d accesses expected %0d", nm, obs.size(), exp.size());
    end else if (bad >= 0) begin
      errors++;
      $display("FAIL %s: access %0d got addr %h expected %h", nm, bad, obs[bad], exp[bad]);
    end
  endtask

  task automatic ram_check(input string nm);
    int bad_cnt;
    int first;
    bad_cnt = 0;
    first = -1;
    foreach (ref_mem[k]) begin
      if (ram[k] !== ref_mem[k]) begin
        bad_cnt++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes wrong, first at %h got %h expected %h",
               nm, bad_cnt, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic preload(input int a, input bit [7:0] d);
    tb_we   = 1'b1;
    tb_addr = a[AW-1:0];
    tb_data = d;
    @(negedge clk);
    #1;
    tb_we = 1'b0;
    ref_mem[a & MSK] = d;
  endtask

  // One transfer; abort_wr>0 aborts during that write cycle, restart_cyc>0
  // re-pulses start (with different operands) during that cycle.
  task automatic run_xfer(input string nm, input bit md, input int sa, input int da,
                          input int ln, input bit [7:0] fd, input int abort_wr,
                          input int restart_cyc, input int exp_done);
    int n, lim, done_cyc, n_done, wr_seen, abort_cyc, busy_bad, overlap, busy_after;
    int exp_w[$], exp_r[$], obs_w[$], obs_r[$];
    n = (abort_wr > 0 && abort_wr < ln) ? abort_wr : ln;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back((da + i) & MSK);
      if (!md) exp_r.push_back((sa + i) & MSK);
      ref_mem[(da + i) & MSK] = md ? fd : ref_mem[(sa + i) & MSK];
    end

    bus.mode      = md;
    bus.src_addr  = sa[AW-1:0];
    bus.dst_addr  = da[AW-1:0];
    bus.length    = ln[LW-1:0];
    bus.fill_data = fd;
    bus.abort     = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;

    lim = 2 * ln + 12;
    done_cyc = -1; n_done = 0; wr_seen = 0; abort_cyc = -1;
    busy_bad = 0; overlap = 0; busy_after = -1;
    for (int cyc = 1; cyc <= lim; cyc++) begin
      if (bus.mem_we && bus.mem_oe) overlap++;
      if (bus.mem_we) begin
        obs_w.push_back(int'(bus.mem_addr));
        wr_seen++;
      end
      if (bus.mem_oe) obs_r.push_back(int'(bus.mem_addr));
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (ln != 0 && abort_cyc < 0 && (done_cyc < 0 || cyc == done_cyc) && !bus.busy)
        busy_bad++;
      if ((done_cyc > 0 && cyc == done_cyc + 1) || (abort_cyc > 0 && cyc == abort_cyc + 1))
        busy_after = int'(bus.busy);
      if (abort_wr > 0 && bus.mem_we && wr_seen == abort_wr) begin
        bus.abort = 1'b1;
        abort_cyc = cyc;
      end
      if (cyc == restart_cyc) begin
        bus.start     = 1'b1;
        bus.mode      = ~md;
        bus.src_addr  = AW'((sa + 16'h1234) & MSK);
        bus.dst_addr  = AW'((da + 16'h0321) & MSK);
        bus.length    = LW'(5);
        bus.fill_data = ~fd;
      end
      if ((done_cyc > 0 && cyc >= done_cyc + 2) || (abort_cyc > 0 && cyc >= abort_cyc + 4))
        break;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    chk({nm, " done_cycle"}, done_cyc, exp_done);
    chk({nm, " done_pulses"}, n_done, (exp_done < 0) ? 0 : 1);
    chk({nm, " busy_low_after"}, busy_after, 0);
    chk({nm, " busy_held"}, busy_bad, 0);
    chk({nm, " we_oe_overlap"}, overlap, 0);
    cmp_q({nm, " write_addrs"}, obs_w, exp_w);
    cmp_q({nm, " read_addrs"}, obs_r, exp_r);
    ram_check({nm, " ram"});
    $display("xfer %-14s mode=%0d src=%h dst=%h len=%0d done_cycle=%0d writes=%0d reads=%0d",
             nm, md, sa, da, ln, done_cyc, obs_w.size(), obs_r.size());
  endtask

  initial begin
    int cnt;
    bit md;
    int sa, da, ln, ed;
    bit [7:0] fd;

    vecs[0] = '{"fill_0100",    1'b1, 'h0000, 'h0100, 4, 8'hA5, 5};
    vecs[1] = '{"copy_0200",    1'b0, 'h0200, 'h0300, 3, 8'h00, 7};
    vecs[2] = '{"fill_wrap",    1'b1, 'h0000, 'h7FFE, 3, 8'h3C, 4};
    vecs[3] = '{"copy_overlap", 1'b0, 'h0400, 'h0401, 3, 8'h00, 7};
    vecs[4] = '{"zero_len",     1'b0, 'h0010, 'h0020, 0, 8'h77, 1};

    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0; bus.fill_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_wdata}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", {bus.busy, bus.done, bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_wdata}, 0);

    preload('h0200, 8'h11);
    preload('h0201, 8'h22);
    preload('h0202, 8'h33);
    preload('h0400, 8'h5A);

    foreach (vecs[i])
      run_xfer(vecs[i].name, vecs[i].md, vecs[i].sa, vecs[i].da, vecs[i].ln,
               vecs[i].fd, 0, 0, vecs[i].exp_done);

    run_xfer("start_in_busy", 1'b1, 'h0000, 'h0600, 8, 8'h96, 0, 3, 9);
    run_xfer("abort_fill", 1'b1, 'h0000, 'h0700, 10, 8'hE7, 3, 0, -1);

    // Reset while a fill is in flight: two bytes land, the rest stay intact.
    for (int i = 0; i < 8; i++) preload('h0500 + i, 8'h00);
    @(posedge clk);
    #1;
    bus.mode = MODE_FILL; bus.dst_addr = AW'('h0500); bus.length = LW'(8);
    bus.fill_data = 8'hC3; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("reset_mid_fill_outputs",
        {bus.busy, bus.done, bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_wdata}, 0);
    ref_mem['h0500] = 8'hC3;
    ref_mem['h0501] = 8'hC3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.mem_we || bus.mem_oe || bus.busy || bus.done) cnt++;
    end
    chk("reset_mid_fill_idle", cnt, 0);
    ram_check("reset_mid_fill ram");
    $display("xfer %-14s reset asserted in write cycle 3", "reset_mid_fill");

    for (int r = 0; r < 12; r++) begin
      md = 1'($urandom_range(0, 1));
      ln = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
      sa = int'($urandom_range(0, MSK));
      da = (r % 4 == 3) ? ((sa + int'($urandom_range(1, 3))) & MSK) : int'($urandom_range(0, MSK));
      if (r % 5 == 4) da = MSK - int'($urandom_range(0, 4));
      fd = 8'($urandom);
      if (!md)
        for (int i = 0; i < ln; i++) preload((sa + i) & MSK, 8'($urandom));
      ed = (ln == 0) ? 1 : (md ? ln + 1 : 2 * ln + 1);
      run_xfer($sformatf("rand_%0d", r), md, sa, da, ln, fd, 0, 0, ed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
